// File: rtl/alu_seq_ctrl.sv
// Microsequencer for the two-mux / add-sub / shift-register datapath: T = (A +/- B +/- C) << shamt.
// Optional SEQ_ACC_EN adds an acc input so ADD1 can add B onto the previous T instead of A.
module alu_seq_ctrl #(
    parameter int SHW = 3
) (
    input  logic           CLK,
    input  logic           Clr,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic [SHW-1:0] shamt,
`ifdef SEQ_ACC_EN
    input  logic           acc,
`endif
    output logic           V0,
    output logic           V1,
    output logic           M,
    output logic           s0,
    output logic           reg_en,
    output logic           busy,
    output logic           done
);

    typedef enum logic [2:0] {IDLE, ADD1, ADD2, SHIFT, DONE} state_t;

    // Control word layout: {V0, V1, M, s0, reg_en, busy, done}
    localparam logic [6:0] CTL_IDLE  = 7'b0000000;
    localparam logic [6:0] CTL_SHIFT = 7'b0001110;
    localparam logic [6:0] CTL_DONE  = 7'b0000001;
    localparam logic [SHW-1:0] ONE   = SHW'(1);

    state_t         state;
    logic           op_sub_c;
    logic [SHW-1:0] sh_q;
    logic [SHW-1:0] cnt;
    logic [6:0]     ctl;
    logic           acc_in;

`ifdef SEQ_ACC_EN
    assign acc_in = acc;
`else
    assign acc_in = 1'b0;
`endif

    assign {V0, V1, M, s0, reg_en, busy, done} = ctl;

    // Outputs are registered together with the state: each branch loads the control word of the state it enters.
    always_ff @(posedge CLK or negedge Clr) begin
        if (!Clr) begin
            state    <= IDLE;
            op_sub_c <= 1'b0;
            sh_q     <= '0;
            cnt      <= '0;
            ctl      <= CTL_IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ADD1;
                        op_sub_c <= op[1];
                        sh_q     <= shamt;
                        ctl      <= {~acc_in, 1'b1, op[0], 1'b0, 1'b1, 1'b1, 1'b0};
                    end else begin
                        ctl <= CTL_IDLE;
                    end
                end
                ADD1: begin
                    state <= ADD2;
                    ctl   <= {1'b0, 1'b0, op_sub_c, 1'b0, 1'b1, 1'b1, 1'b0};
                end
                ADD2: begin
                    cnt <= sh_q;
                    if (sh_q != '0) begin
                        state <= SHIFT;
                        ctl   <= CTL_SHIFT;
                    end else begin
                        state <= DONE;
                        ctl   <= CTL_DONE;
                    end
                end
                SHIFT: begin
                    cnt <= cnt - ONE;
                    if (cnt == ONE) begin
                        state <= DONE;
                        ctl   <= CTL_DONE;
                    end else begin
                        ctl <= CTL_SHIFT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ctl   <= CTL_IDLE;
                end
                default: begin
                    state <= IDLE;
                    ctl   <= CTL_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: drives operations into a small datapath model and checks
// the per-cycle control word and the final T against (A +/- B +/- C) << shamt.
module tb_alu_seq_ctrl;

    logic       CLK;
    logic       Clr;
    logic       start;
    logic [1:0] op;
    logic [2:0] shamt;
    logic       acc;
    logic       V0, V1, M, s0, reg_en, busy, done;
    logic [7:0] A, B, C, T;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] last_t = 8'h00;

`ifdef SEQ_ACC_EN
    localparam bit ACC_ON = 1'b1;
`else
    localparam bit ACC_ON = 1'b0;
`endif

    localparam logic [6:0] EXP_IDLE  = 7'b0000000;
    localparam logic [6:0] EXP_SHIFT = 7'b0001110;
    localparam logic [6:0] EXP_DONE  = 7'b0000001;

    alu_seq_ctrl #(.SHW(3)) dut (
        .CLK(CLK),
        .Clr(Clr),
        .start(start),
        .op(op),
        .shamt(shamt),
`ifdef SEQ_ACC_EN
        .acc(acc),
`endif
        .V0(V0),
        .V1(V1),
        .M(M),
        .s0(s0),
        .reg_en(reg_en),
        .busy(busy),
        .done(done)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // datapath: muxes, adder/subtractor, shift/load register, zero fill
    always_ff @(posedge CLK or negedge Clr) begin
        if (!Clr)
            T <= 8'h00;
        else if (reg_en) begin
            if (s0)
                T <= {T[6:0], 1'b0};
            else
                T <= M ? ((V0 ? A : T) - (V1 ? B : C)) : ((V0 ? A : T) + (V1 ? B : C));
        end
    end

    function automatic logic [6:0] ctl_obs();
        return {V0, V1, M, s0, reg_en, busy, done};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // poke: 0 = start low while busy, 1 = random start pulses, 2 = start held high throughout
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [1:0] o, input logic [2:0] sh, input logic ac, input int poke);
        logic [6:0] exp_q[$];
        logic [6:0] ev;
        logic [7:0] exp_t;
        logic       ac_eff;
        int         busy_n;
        ac_eff = ACC_ON ? ac : 1'b0;
        exp_t  = ac_eff ? last_t : a;
        exp_t  = o[0] ? exp_t - b : exp_t + b;
        exp_t  = o[1] ? exp_t - c : exp_t + c;
        exp_t  = exp_t << sh;
        exp_q.push_back({~ac_eff, 1'b1, o[0], 4'b0110});
        exp_q.push_back({2'b00, o[1], 4'b0110});
        for (int i = 0; i < int'(sh); i++) exp_q.push_back(EXP_SHIFT);
        exp_q.push_back(EXP_DONE);

        @(negedge CLK);
        A = a; B = b; C = c; op = o; shamt = sh; acc = ac; start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        // inputs the sequencer latched must no longer matter
        op = ~o; shamt = ~sh; acc = ~ac;
        busy_n = 0;
        while (exp_q.size() > 0) begin
            @(negedge CLK);
            ev = exp_q.pop_front();
            check("ctl", 32'(ctl_obs()), 32'(ev));
            busy_n += int'(busy);
            if (ev == EXP_DONE) check("t_final", 32'(T), 32'(exp_t));
            start = (poke == 2) || (poke == 1 && $urandom_range(0, 2) == 0);
        end
        @(negedge CLK);
        start = 1'b0;
        check("idle_after_done", 32'(ctl_obs()), 32'(EXP_IDLE));
        check("busy_cycles", 32'(busy_n), 32'(2 + int'(sh)));
        @(negedge CLK);
        check("no_queued_start", 32'(ctl_obs()), 32'(EXP_IDLE));
        last_t = exp_t;
    endtask

    initial begin
        Clr = 1'b0; start = 1'b0; op = 2'b00; shamt = 3'd0; acc = 1'b0;
        A = 8'h00; B = 8'h00; C = 8'h00;
        repeat (2) @(negedge CLK);
        check("reset_ctl", 32'(ctl_obs()), 32'(EXP_IDLE));
        check("reset_t", 32'(T), 32'h0);
        Clr = 1'b1;
        @(negedge CLK);
        check("idle_no_start", 32'(ctl_obs()), 32'(EXP_IDLE));

        run_op(8'd2, 8'd4, 8'd3, 2'b01, 3'd1, 1'b0, 0);
        run_op(8'd2, 8'd4, 8'd3, 2'b10, 3'd1, 1'b0, 0);
        run_op(8'hF0, 8'h20, 8'h00, 2'b00, 3'd0, 1'b0, 0);
        run_op(8'd1, 8'd0, 8'd0, 2'b00, 3'd7, 1'b0, 2);

        // asynchronous reset in the middle of the shift phase
        @(negedge CLK);
        A = 8'h13; B = 8'h05; C = 8'h07; op = 2'b00; shamt = 3'd5; start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        repeat (4) @(negedge CLK);
        check("mid_shift_busy", 32'(busy), 32'h1);
        #2 Clr = 1'b0;
        #1;
        check("clr_ctl", 32'(ctl_obs()), 32'(EXP_IDLE));
        check("clr_t", 32'(T), 32'h0);
        @(negedge CLK);
        Clr = 1'b1;
        last_t = 8'h00;
        @(negedge CLK);
        check("post_clr_idle", 32'(ctl_obs()), 32'(EXP_IDLE));
        run_op(8'h13, 8'h05, 8'h07, 2'b11, 3'd2, 1'b0, 0);

        if (ACC_ON) begin
            run_op(8'd3, 8'd2, 8'd0, 2'b00, 3'd0, 1'b0, 0);
            run_op(8'd9, 8'd1, 8'd0, 2'b00, 3'd0, 1'b1, 0);
        end

        for (int k = 0; k < 40; k++) begin
            run_op(8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)),
                   3'($urandom_range(0, 7)), ACC_ON ? 1'($urandom_range(0, 1)) : 1'b0,
                   int'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
